// File: rtl/rca_pipe_if.sv
// rtl/rca_pipe_if.sv - operand/result stream bundle for rca_pipe; ovf exists only with RCA_PIPE_OVF_EN
interface rca_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
`ifdef RCA_PIPE_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, s, cout
`ifdef RCA_PIPE_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, s, cout
`ifdef RCA_PIPE_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/rca_pipe.sv
// rtl/rca_pipe.sv - pipelined ripple-carry adder, one register boundary per SW-bit slice
// Optional signed overflow output enabled by RCA_PIPE_OVF_EN.
module rca_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic       clk,
  input logic       rst_n,
  rca_pipe_if.slave bus
);
  localparam int SW = (STAGES > 0) ? WIDTH / STAGES : 1;

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("rca_pipe: WIDTH must be a positive multiple of STAGES");
  end

  logic adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * SW;
    localparam int HI = LO + SW;

    // in_a/in_b hold only the operand bits not yet added: this slice plus everything above it
    logic [WIDTH-LO-1:0] in_a;
    logic [WIDTH-LO-1:0] in_b;
    logic                in_c;
    logic                in_v;
    logic [SW-1:0]       sl_s;
    logic                sl_c;
    logic [HI-1:0]       s_d;
    logic                v_q;
    logic                c_q;
    logic [HI-1:0]       s_q;

    if (k == 0) begin : g_src
      assign in_a = bus.a;
      assign in_b = bus.b;
      assign in_c = bus.cin;
      assign in_v = bus.in_valid;
      assign s_d  = sl_s;
    end else begin : g_src
      assign in_a = g_st[k-1].g_op.a_q;
      assign in_b = g_st[k-1].g_op.b_q;
      assign in_c = g_st[k-1].c_q;
      assign in_v = g_st[k-1].v_q;
      assign s_d  = {sl_s, g_st[k-1].s_q};
    end

    always_comb begin
      logic c;
      c    = in_c;
      sl_s = '0;
      for (int i = 0; i < SW; i++) begin
        sl_s[i] = in_a[i] ^ in_b[i] ^ c;
        c       = (in_a[i] & in_b[i]) | (c & (in_a[i] ^ in_b[i]));
      end
      sl_c = c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= in_v;
        if (in_v) begin
          c_q <= sl_c;
          s_q <= s_d;
        end
      end
    end

    if (k < STAGES - 1) begin : g_op
      logic [WIDTH-HI-1:0] a_q;
      logic [WIDTH-HI-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv && in_v) begin
          a_q <= in_a[WIDTH-LO-1:SW];
          b_q <= in_b[WIDTH-LO-1:SW];
        end
      end
    end
  end

  // Whole pipe moves as one: a bubble in the last stage frees every slot upstream
  assign adv           = !g_st[STAGES-1].v_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = g_st[STAGES-1].v_q;
  assign bus.s         = g_st[STAGES-1].s_q;
  assign bus.cout      = g_st[STAGES-1].c_q;

`ifdef RCA_PIPE_OVF_EN
  logic sa_q;
  logic sb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q <= 1'b0;
      sb_q <= 1'b0;
    end else if (adv && g_st[STAGES-1].in_v) begin
      sa_q <= g_st[STAGES-1].in_a[SW-1];
      sb_q <= g_st[STAGES-1].in_b[SW-1];
    end
  end

  assign bus.ovf = (sa_q == sb_q) && (g_st[STAGES-1].s_q[WIDTH-1] != sa_q);
`endif
endmodule
